// File: rtl/fpu_ss_wb_arbiter.sv
// Write-back arbiter: buffers FPnew results in a small FIFO and retires them to the
// FP register file or the core's integer result port; memory loads always win the FPR port.
module fpu_ss_wb_arbiter #(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fpu_out_valid_i,
  output logic        fpu_out_ready_o,
  input  logic [31:0] fpu_out_data_i,
  input  logic [4:0]  fpu_out_rd_i,
  input  logic        fpu_out_rd_is_fp_i,
  input  logic [3:0]  fpu_out_id_i,
  input  logic        mem_result_valid_i,
  input  logic        mem_result_we_i,
  input  logic [4:0]  mem_result_rd_i,
  input  logic [31:0] mem_result_data_i,
  output logic        fpr_we_o,
  output logic [4:0]  fpr_waddr_o,
  output logic [31:0] fpr_wdata_o,
  output logic        x_result_valid_o,
  input  logic        x_result_ready_i,
  output logic [3:0]  x_result_id_o,
  output logic [4:0]  x_result_rd_o,
  output logic [31:0] x_result_data_o,
  output logic        empty_o
);

  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(BUF_DEPTH);

  logic [31:0]   buf_data  [BUF_DEPTH];
  logic [4:0]    buf_rd    [BUF_DEPTH];
  logic          buf_is_fp [BUF_DEPTH];
  logic [3:0]    buf_id    [BUF_DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;

  logic          empty, push, pop, mem_wr, fp_pop, x_valid, x_pop;
  logic [31:0]   head_data;
  logic [4:0]    head_rd;
  logic          head_is_fp;
  logic [3:0]    head_id;

  assign empty      = (count == '0);
  assign head_data  = buf_data[rd_ptr];
  assign head_rd    = buf_rd[rd_ptr];
  assign head_is_fp = buf_is_fp[rd_ptr];
  assign head_id    = buf_id[rd_ptr];

  // Loads are gated by reset so the FPR port stays quiet while the block is held in reset.
  assign mem_wr  = rst_ni & mem_result_valid_i & mem_result_we_i;
  assign fp_pop  = ~empty & head_is_fp & ~mem_wr;
  assign x_valid = ~empty & ~head_is_fp;
  assign x_pop   = x_valid & x_result_ready_i;
  assign pop     = fp_pop | x_pop;

  assign fpu_out_ready_o = (count < DEPTH_C);
  assign push            = fpu_out_valid_i & fpu_out_ready_o;
  assign empty_o         = empty;

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_data[wr_ptr]  <= fpu_out_data_i;
      buf_rd[wr_ptr]    <= fpu_out_rd_i;
      buf_is_fp[wr_ptr] <= fpu_out_rd_is_fp_i;
      buf_id[wr_ptr]    <= fpu_out_id_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    fpr_we_o    = 1'b0;
    fpr_waddr_o = '0;
    fpr_wdata_o = '0;
    if (mem_wr) begin
      fpr_we_o    = 1'b1;
      fpr_waddr_o = mem_result_rd_i;
      fpr_wdata_o = mem_result_data_i;
    end else if (fp_pop) begin
      fpr_we_o    = 1'b1;
      fpr_waddr_o = head_rd;
      fpr_wdata_o = head_data;
    end
  end

  always_comb begin
    x_result_valid_o = x_valid;
    x_result_id_o    = '0;
    x_result_rd_o    = '0;
    x_result_data_o  = '0;
    if (x_valid) begin
      x_result_id_o   = head_id;
      x_result_rd_o   = head_rd;
      x_result_data_o = head_data;
    end
  end

endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
// Bench for fpu_ss_wb_arbiter: directed vector table, reset sequences and random traffic
// checked against a queue-based model of the write-back rules.
module tb_fpu_ss_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fpu_v, fpu_ready, fpu_is_fp;
  logic [31:0] fpu_data;
  logic [4:0]  fpu_rd;
  logic [3:0]  fpu_id;
  logic        mem_v, mem_we;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        fpr_we;
  logic [4:0]  fpr_waddr;
  logic [31:0] fpr_wdata;
  logic        xv, x_ready;
  logic [3:0]  xid;
  logic [4:0]  xrd;
  logic [31:0] xdata;
  logic        empty;

  always #5 clk = ~clk;

  fpu_ss_wb_arbiter #(.BUF_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .fpu_out_valid_i(fpu_v), .fpu_out_ready_o(fpu_ready),
    .fpu_out_data_i(fpu_data), .fpu_out_rd_i(fpu_rd),
    .fpu_out_rd_is_fp_i(fpu_is_fp), .fpu_out_id_i(fpu_id),
    .mem_result_valid_i(mem_v), .mem_result_we_i(mem_we),
    .mem_result_rd_i(mem_rd), .mem_result_data_i(mem_data),
    .fpr_we_o(fpr_we), .fpr_waddr_o(fpr_waddr), .fpr_wdata_o(fpr_wdata),
    .x_result_valid_o(xv), .x_result_ready_i(x_ready),
    .x_result_id_o(xid), .x_result_rd_o(xrd), .x_result_data_o(xdata),
    .empty_o(empty)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        xv;
    logic [3:0]  xid;
    logic [4:0]  xrd;
    logic [31:0] xdata;
    logic        ready;
    logic        empty;
  } out_t;

  typedef struct packed {
    logic        fv;
    logic [31:0] fdata;
    logic [4:0]  frd;
    logic        ffp;
    logic [3:0]  fid;
    logic        mv;
    logic        mwe;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    logic        xr;
  } in_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        is_fp;
    logic [3:0]  id;
  } entry_t;

  entry_t q[$];
  vec_t   tab[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  function automatic in_t mi(logic fv, logic [31:0] fdata, logic [4:0] frd, logic ffp,
                             logic [3:0] fid, logic mv, logic mwe, logic [4:0] mrd,
                             logic [31:0] mdata, logic xr);
    mi = {fv, fdata, frd, ffp, fid, mv, mwe, mrd, mdata, xr};
  endfunction

  function automatic out_t mo(logic we, logic [4:0] waddr, logic [31:0] wdata, logic v,
                              logic [3:0] id, logic [4:0] rd, logic [31:0] data,
                              logic rdy, logic emp);
    mo = {we, waddr, wdata, v, id, rd, data, rdy, emp};
  endfunction

  function automatic in_t idle(logic xr);
    idle = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, xr);
  endfunction

  task automatic apply(in_t v);
    fpu_v = v.fv; fpu_data = v.fdata; fpu_rd = v.frd; fpu_is_fp = v.ffp; fpu_id = v.fid;
    mem_v = v.mv; mem_we = v.mwe; mem_rd = v.mrd; mem_data = v.mdata; x_ready = v.xr;
  endtask

  // Reference: FPR port goes to a load if present, else to an FP head; an integer head is
  // offered to the core; at most the head leaves per cycle, then an accepted push joins the tail.
  function automatic out_t model_out();
    out_t e;
    e = '0;
    e.ready = (q.size() < DEPTH);
    e.empty = (q.size() == 0);
    if (rst_n && mem_v && mem_we) begin
      e.we = 1'b1; e.waddr = mem_rd; e.wdata = mem_data;
    end else if (q.size() > 0 && q[0].is_fp) begin
      e.we = 1'b1; e.waddr = q[0].rd; e.wdata = q[0].data;
    end
    if (q.size() > 0 && !q[0].is_fp) begin
      e.xv = 1'b1; e.xid = q[0].id; e.xrd = q[0].rd; e.xdata = q[0].data;
    end
    return e;
  endfunction

  task automatic model_clock();
    bit pop, rdy;
    if (!rst_n) return;
    pop = 1'b0;
    if (q.size() > 0) pop = q[0].is_fp ? !(mem_v && mem_we) : x_ready;
    rdy = (q.size() < DEPTH);
    if (pop) void'(q.pop_front());
    if (fpu_v && rdy) q.push_back({fpu_data, fpu_rd, fpu_is_fp, fpu_id});
  endtask

  task automatic cmp(string tag, string f, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%0h required 0x%0h", tag, f, act, exp);
    end
  endtask

  task automatic check_outs(string tag, out_t e);
    cmp(tag, "fpr_we", 32'(fpr_we), 32'(e.we));
    cmp(tag, "fpr_waddr", 32'(fpr_waddr), 32'(e.waddr));
    cmp(tag, "fpr_wdata", fpr_wdata, e.wdata);
    cmp(tag, "x_valid", 32'(xv), 32'(e.xv));
    cmp(tag, "x_id", 32'(xid), 32'(e.xid));
    cmp(tag, "x_rd", 32'(xrd), 32'(e.xrd));
    cmp(tag, "x_data", xdata, e.xdata);
    cmp(tag, "ready", 32'(fpu_ready), 32'(e.ready));
    cmp(tag, "empty", 32'(empty), 32'(e.empty));
  endtask

  // Check at the falling edge, then advance the model across the rising edge.
  task automatic step(string tag, bit use_tab, out_t tab_e);
    @(negedge clk);
    check_outs(tag, use_tab ? tab_e : model_out());
    @(posedge clk);
    model_clock();
    #1;
  endtask

  initial begin
    out_t rst_e;
    rst_e = mo(0, 0, 0, 0, 0, 0, 0, 1, 1);

    // Held in reset with traffic on every input: nothing may come out or be stored.
    rst_n = 1'b0;
    apply(mi(1, 32'hDEAD0001, 6, 1, 2, 1, 1, 5, 32'hBEEF0000, 1));
    step("reset0", 1, rst_e);
    step("reset1", 1, rst_e);
    rst_n = 1'b1;
    q.delete();

    tab.push_back({mi(1, 32'h3F800000, 3, 1, 1, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0, 1, 1)});
    tab.push_back({idle(0), mo(1, 3, 32'h3F800000, 0, 0, 0, 0, 1, 0)});
    tab.push_back({idle(0), mo(0, 0, 0, 0, 0, 0, 0, 1, 1)});
    tab.push_back({mi(1, 32'h40000000, 5, 1, 2, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0, 1, 1)});
    for (int unsigned k = 1; k <= 3; k++)
      tab.push_back({mi(0, 0, 0, 0, 0, 1, 1, 7, 32'hAAAA0000 + k, 0),
                     mo(1, 7, 32'hAAAA0000 + k, 0, 0, 0, 0, 1, 0)});
    tab.push_back({idle(0), mo(1, 5, 32'h40000000, 0, 0, 0, 0, 1, 0)});
    tab.push_back({idle(0), mo(0, 0, 0, 0, 0, 0, 0, 1, 1)});
    tab.push_back({mi(1, 32'h12345678, 10, 0, 9, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0, 1, 1)});
    for (int unsigned k = 0; k < 4; k++)
      tab.push_back({idle(0), mo(0, 0, 0, 1, 9, 10, 32'h12345678, 1, 0)});
    tab.push_back({idle(1), mo(0, 0, 0, 1, 9, 10, 32'h12345678, 1, 0)});
    tab.push_back({idle(0), mo(0, 0, 0, 0, 0, 0, 0, 1, 1)});
    tab.push_back({mi(0, 0, 0, 0, 0, 1, 0, 4, 32'hFF, 0), mo(0, 0, 0, 0, 0, 0, 0, 1, 1)});
    tab.push_back({mi(1, 32'h11, 1, 0, 3, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0, 1, 1)});
    tab.push_back({mi(1, 32'h22, 2, 0, 4, 0, 0, 0, 0, 0), mo(0, 0, 0, 1, 3, 1, 32'h11, 1, 0)});
    tab.push_back({mi(1, 32'h33, 3, 0, 5, 0, 0, 0, 0, 0), mo(0, 0, 0, 1, 3, 1, 32'h11, 0, 0)});
    tab.push_back({mi(1, 32'h33, 3, 0, 5, 0, 0, 0, 0, 1), mo(0, 0, 0, 1, 3, 1, 32'h11, 0, 0)});
    tab.push_back({mi(1, 32'h33, 3, 0, 5, 0, 0, 0, 0, 1), mo(0, 0, 0, 1, 4, 2, 32'h22, 1, 0)});
    tab.push_back({mi(1, 32'h66, 8, 1, 6, 0, 0, 0, 0, 1), mo(0, 0, 0, 1, 5, 3, 32'h33, 1, 0)});
    tab.push_back({mi(1, 32'h77, 9, 0, 7, 0, 0, 0, 0, 0), mo(1, 8, 32'h66, 0, 0, 0, 0, 1, 0)});
    tab.push_back({idle(1), mo(0, 0, 0, 1, 7, 9, 32'h77, 1, 0)});
    tab.push_back({idle(0), mo(0, 0, 0, 0, 0, 0, 0, 1, 1)});
    tab.push_back({mi(1, 32'h88, 11, 0, 8, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0, 1, 1)});
    tab.push_back({mi(1, 32'hAA, 12, 1, 10, 0, 0, 0, 0, 0), mo(0, 0, 0, 1, 8, 11, 32'h88, 1, 0)});
    tab.push_back({idle(0), mo(0, 0, 0, 1, 8, 11, 32'h88, 0, 0)});
    tab.push_back({idle(1), mo(0, 0, 0, 1, 8, 11, 32'h88, 0, 0)});
    tab.push_back({idle(0), mo(1, 12, 32'hAA, 0, 0, 0, 0, 1, 0)});
    tab.push_back({idle(0), mo(0, 0, 0, 0, 0, 0, 0, 1, 1)});

    // Row 0 pushes on the very first edge after reset release.
    foreach (tab[i]) begin
      apply(tab[i].in);
      step($sformatf("vec%0d", i), 1, tab[i].exp);
    end

    // Reset with two integer entries stalled in the buffer.
    apply(mi(1, 32'h101, 1, 0, 1, 0, 0, 0, 0, 0));
    step("pre_rst0", 0, '0);
    apply(mi(1, 32'h102, 2, 0, 2, 0, 0, 0, 0, 0));
    step("pre_rst1", 0, '0);
    apply(idle(0));
    step("pre_rst2", 0, '0);
    rst_n = 1'b0;
    q.delete();
    step("mid_rst", 1, rst_e);
    rst_n = 1'b1;
    apply(idle(1));
    step("post_rst0", 1, rst_e);
    step("post_rst1", 1, rst_e);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        q.delete();
      end else begin
        rst_n = 1'b1;
      end
      apply(mi($urandom_range(0, 1), $urandom, 5'($urandom), $urandom_range(0, 1),
               4'($urandom), $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7,
               5'($urandom), $urandom, $urandom_range(0, 1)));
      step($sformatf("rnd%0d", n), 0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
